noc_route_decoder: RTL and testbench

- Parametrised successor to the fixed 2-way decoder leaf.
- Accepts one flit per packet on a valid/ready input channel and extracts an address field.
- Computes a destination port in either tree mode (bit-slice select) or leaf mode (masked match).
- Emits the selected port index on a side channel S, then forwards the flit to one of NUM_OUT outputs, strictly in that order. Sits at every NoC decode-tree node.

---
 rtl/noc_route_pkg.sv | 49 ++++
 rtl/noc_route_select.sv | 29 ++
 rtl/noc_route_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_noc_route_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_route_pkg.sv
// noc_route_pkg: shared types, constants and the port computation used by the
// NoC route decoder (optional statistics enabled with NOC_ROUTE_STATS_EN).
package noc_route_pkg;

    // Width of every statistics counter.
    localparam int STAT_W      = 16;

    // Widest address field / shift / select the helper function handles.
    localparam int ADDR_MAX_W  = 16;
    localparam int SHIFT_MAX_W = 4;
    localparam int SEL_MAX_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        DATA = 2'd2
    } route_state_e;

    typedef enum logic {
        TREE = 1'b0,
        LEAF = 1'b1
    } route_mode_e;

    // Destination port for address a. Tree mode takes a bit slice starting at
    // 'shift'; because a is zero-extended, slice bits above the real address
    // field read as 0. Leaf mode routes hits to port 0 and misses upstream to
    // the highest port. num_out is the node's port count (a power of 2).
    function automatic logic [SEL_MAX_W-1:0] port_of(
        input logic [ADDR_MAX_W-1:0]  a,
        input route_mode_e            mode,
        input logic [ADDR_MAX_W-1:0]  addr,
        input logic [ADDR_MAX_W-1:0]  mask,
        input logic [SHIFT_MAX_W-1:0] shift,
        input logic [SEL_MAX_W:0]     num_out
    );
        logic [ADDR_MAX_W-1:0] sel_mask;
        logic [SEL_MAX_W-1:0]  res;
        sel_mask = ADDR_MAX_W'(num_out) - 16'd1;
        if (mode == TREE) begin
            res = SEL_MAX_W'((a >> shift) & sel_mask);
        end else if ((a & mask) == (addr & mask)) begin
            res = 4'd0;
        end else begin
            res = SEL_MAX_W'(sel_mask);
        end
        return res;
    endfunction

endpackage

// File: rtl/noc_route_select.sv
// noc_route_select: combinational destination-port computation for one flit
// address, in tree (bit-slice) or leaf (masked match) mode.
module noc_route_select
    import noc_route_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int NUM_OUT = 2,
    localparam int SEL_W   = $clog2(NUM_OUT),
    localparam int SHIFT_W = $clog2(ADDR_W)
) (
    input  logic [ADDR_W-1:0]  addr_field,
    input  logic               cfg_mode,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ADDR_W-1:0]  cfg_mask,
    input  logic [SHIFT_W-1:0] cfg_shift,
    output logic [SEL_W-1:0]   port
);

    // Widen every operand to the helper's fixed widths and keep the low bits.
    always_comb begin
        port = SEL_W'(port_of(ADDR_MAX_W'(addr_field),
                              route_mode_e'(cfg_mode),
                              ADDR_MAX_W'(cfg_addr),
                              ADDR_MAX_W'(cfg_mask),
                              SHIFT_MAX_W'(cfg_shift),
                              5'(NUM_OUT)));
    end

endmodule

// File: rtl/noc_route_decoder.sv
// noc_route_decoder: one-flit-per-packet NoC decode-tree node. Accepts a flit,
// announces the chosen port on the S side channel, then presents the flit on
// that output. Optional per-port statistics are built when the macro
// NOC_ROUTE_STATS_EN is defined.
module noc_route_decoder
    import noc_route_pkg::*;
#(
    parameter int DATA_W   = 9,
    parameter int ADDR_LSB = 5,
    parameter int ADDR_W   = 4,
    parameter int NUM_OUT  = 2,
    localparam int SEL_W      = $clog2(NUM_OUT),
    localparam int SHIFT_W    = $clog2(ADDR_W),
    localparam int STAT_SEL_W = $clog2(NUM_OUT + 1)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               cfg_mode,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ADDR_W-1:0]  cfg_mask,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               s_valid,
    input  logic               s_ready,
    output logic [SEL_W-1:0]   s_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data
`ifdef NOC_ROUTE_STATS_EN
    ,
    input  logic [STAT_SEL_W-1:0] stat_sel,
    input  logic                  stat_clr,
    output logic [STAT_W-1:0]     stat_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_SEL  = 2'(SEL);
    localparam logic [1:0] ST_DATA = 2'(DATA);

    localparam logic [NUM_OUT-1:0] PORT0_ONEHOT = {{(NUM_OUT-1){1'b0}}, 1'b1};

    logic [1:0]         state_r;
    logic               in_ready_r;
    logic               s_valid_r;
    logic [SEL_W-1:0]   s_data_r;
    logic [NUM_OUT-1:0] out_valid_r;
    logic [DATA_W-1:0]  out_data_r;
    logic [DATA_W-1:0]  flit_r;
    logic [SEL_W-1:0]   port_r;
    logic [SEL_W-1:0]   port_s;
    logic               accept_s;
    logic               out_fire_s;

    // Port for the flit currently offered; only used on the accepting edge, so
    // the configuration is effectively sampled together with the flit.
    noc_route_select #(
        .ADDR_W  (ADDR_W),
        .NUM_OUT (NUM_OUT)
    ) u_select (
        .addr_field (in_data[ADDR_LSB +: ADDR_W]),
        .cfg_mode   (cfg_mode),
        .cfg_addr   (cfg_addr),
        .cfg_mask   (cfg_mask),
        .cfg_shift  (cfg_shift),
        .port       (port_s)
    );

    // Handshake qualifiers for the input and the selected output port.
    always_comb begin
        accept_s   = 1'b0;
        out_fire_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = in_ready_r & in_valid;
        end else if (state_r == ST_DATA) begin
            out_fire_s = out_ready[port_r];
        end else begin
            accept_s   = 1'b0;
            out_fire_s = 1'b0;
        end
    end

    // Control FSM; every output is a register loaded from the transition, so
    // s_valid and out_valid can never overlap and in_ready stays low in reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            s_valid_r   <= 1'b0;
            s_data_r    <= {SEL_W{1'b0}};
            out_valid_r <= {NUM_OUT{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            flit_r      <= {DATA_W{1'b0}};
            port_r      <= {SEL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        flit_r     <= in_data;
                        port_r     <= port_s;
                        s_data_r   <= port_s;
                        s_valid_r  <= 1'b1;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SEL;
                    end else begin
                        // First idle cycle after reset opens the input.
                        in_ready_r <= 1'b1;
                    end
                end
                ST_SEL: begin
                    if (s_ready) begin
                        s_valid_r   <= 1'b0;
                        out_valid_r <= PORT0_ONEHOT << port_r;
                        out_data_r  <= flit_r;
                        state_r     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (out_fire_s) begin
                        out_valid_r <= {NUM_OUT{1'b0}};
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    s_valid_r   <= 1'b0;
                    out_valid_r <= {NUM_OUT{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign s_valid   = s_valid_r;
    assign s_data    = s_data_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

`ifdef NOC_ROUTE_STATS_EN
    route_mode_e        mode_r;
    logic [STAT_W-1:0]  port_cnt_r [NUM_OUT];
    logic [STAT_W-1:0]  miss_cnt_r;
    logic [STAT_W-1:0]  stat_cnt_r;
    logic [STAT_W-1:0]  stat_pick_s;

    // Mode of the in-flight packet, needed to tell leaf misses from tree routes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_r <= TREE;
        end else if (accept_s) begin
            mode_r <= route_mode_e'(cfg_mode);
        end
    end

    // Saturating counters of completed output handshakes; clear has priority.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                port_cnt_r[i] <= {STAT_W{1'b0}};
            end
            miss_cnt_r <= {STAT_W{1'b0}};
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                port_cnt_r[i] <= {STAT_W{1'b0}};
            end
            miss_cnt_r <= {STAT_W{1'b0}};
        end else if (out_fire_s) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if ((port_r == SEL_W'(i)) && (port_cnt_r[i] != {STAT_W{1'b1}})) begin
                    port_cnt_r[i] <= port_cnt_r[i] + 16'd1;
                end
            end
            if ((mode_r == LEAF) && (port_r == SEL_W'(NUM_OUT - 1)) &&
                (miss_cnt_r != {STAT_W{1'b1}})) begin
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end

    // Read mux: stat_sel == NUM_OUT selects the miss counter, larger reads 0.
    always_comb begin
        stat_pick_s = {STAT_W{1'b0}};
        if (stat_sel == STAT_SEL_W'(NUM_OUT)) begin
            stat_pick_s = miss_cnt_r;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (stat_sel == STAT_SEL_W'(i)) begin
                    stat_pick_s = port_cnt_r[i];
                end
            end
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_cnt_r <= {STAT_W{1'b0}};
        end else begin
            stat_cnt_r <= stat_pick_s;
        end
    end

    assign stat_cnt = stat_cnt_r;
`endif

endmodule

// File: tb/tb_noc_route_decoder.sv
// tb_noc_route_decoder: checks a 2-port and a 4-port decoder node with a table
// of routing vectors, hand-written backpressure/reset/throughput sequences and
// randomized packets against an arithmetic routing model.
module tb_noc_route_decoder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       cfg_mode;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_mask;
    logic [1:0] cfg_shift;
    logic [8:0] in_data;

    logic       iv2, ir2, sv2, sr2;
    logic [0:0] sd2;
    logic [1:0] ov2, or2;
    logic [8:0] od2;
    logic       iv4, ir4, sv4, sr4;
    logic [1:0] sd4;
    logic [3:0] ov4, or4;
    logic [8:0] od4;

    int vectors     = 0;
    int miscompares = 0;
    int shs2 = 0, ohs2 = 0, shs4 = 0, ohs4 = 0;

`ifdef NOC_ROUTE_STATS_EN
    logic [1:0]  stat_sel2;
    logic        stat_clr2;
    logic [15:0] stat_cnt2;
    logic [2:0]  stat_sel4;
    logic        stat_clr4;
    logic [15:0] stat_cnt4;
`endif

    always #5 CLK = ~CLK;

    noc_route_decoder #(.NUM_OUT(2)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .cfg_mode(cfg_mode), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_shift(cfg_shift), .in_valid(iv2), .in_ready(ir2),
        .in_data(in_data), .s_valid(sv2), .s_ready(sr2), .s_data(sd2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef NOC_ROUTE_STATS_EN
        , .stat_sel(stat_sel2), .stat_clr(stat_clr2), .stat_cnt(stat_cnt2)
`endif
    );

    noc_route_decoder #(.NUM_OUT(4)) u_dut4 (
        .CLK(CLK), .RESET(RESET), .cfg_mode(cfg_mode), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_shift(cfg_shift), .in_valid(iv4), .in_ready(ir4),
        .in_data(in_data), .s_valid(sv4), .s_ready(sr4), .s_data(sd4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4)
`ifdef NOC_ROUTE_STATS_EN
        , .stat_sel(stat_sel4), .stat_clr(stat_clr4), .stat_cnt(stat_cnt4)
`endif
    );

    // Count completed handshakes on each channel of each node.
    always @(posedge CLK) begin
        if (sv2 && sr2) shs2 <= shs2 + 1;
        if ((ov2 & or2) != 2'd0) ohs2 <= ohs2 + 1;
        if (sv4 && sr4) shs4 <= shs4 + 1;
        if ((ov4 & or4) != 4'd0) ohs4 <= ohs4 + 1;
    end

    typedef struct packed {
        logic       in_ready;
        logic       s_valid;
        logic [3:0] s_data;
        logic [3:0] out_valid;
        logic [8:0] out_data;
    } obs_t;

    typedef struct {
        int         d;
        logic [8:0] flit;
        logic       mode;
        logic [3:0] addr;
        logic [3:0] mask;
        logic [1:0] shift;
        int         exp_port;
    } vec_t;

    function automatic obs_t look(input int d);
        obs_t o;
        if (d == 2) begin
            o.in_ready = ir2; o.s_valid = sv2; o.s_data = {3'd0, sd2};
            o.out_valid = {2'd0, ov2}; o.out_data = od2;
        end else begin
            o.in_ready = ir4; o.s_valid = sv4; o.s_data = {2'd0, sd4};
            o.out_valid = ov4; o.out_data = od4;
        end
        return o;
    endfunction

    function automatic int shs(input int d);
        return (d == 2) ? shs2 : shs4;
    endfunction

    function automatic int ohs(input int d);
        return (d == 2) ? ohs2 : ohs4;
    endfunction

    // Routing rule written directly from the address arithmetic.
    function automatic int model_port(input int d, input logic [8:0] flit, input logic mode,
                                      input logic [3:0] addr, input logic [3:0] mask,
                                      input logic [1:0] shift);
        int a;
        a = (int'(flit) / 32) % 16;
        if (mode == 1'b0) return (a / (1 << int'(shift))) % d;
        if ((a & int'(mask)) == (int'(addr) & int'(mask))) return 0;
        return d - 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ctl(input int d, input logic iv, input logic sr, input logic [3:0] orv);
        iv2 = 1'b0; sr2 = 1'b0; or2 = 2'd0;
        iv4 = 1'b0; sr4 = 1'b0; or4 = 4'd0;
        if (d == 2) begin
            iv2 = iv; sr2 = sr; or2 = orv[1:0];
        end else begin
            iv4 = iv; sr4 = sr; or4 = orv;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One full packet with optional stalls on S and on the output, optional
    // config/data scramble right after acceptance.
    task automatic send(input int d, input logic [8:0] flit, input logic mode,
                        input logic [3:0] addr, input logic [3:0] mask, input logic [1:0] shift,
                        input int exp_port, input int s_stall, input int o_stall, input bit toggle);
        obs_t o;
        int s0, o0;
        logic [3:0] onehot, others;
        onehot = 4'd1 << exp_port;
        others = ((d == 2) ? 4'b0011 : 4'b1111) & ~onehot;
        cfg_mode = mode; cfg_addr = addr; cfg_mask = mask; cfg_shift = shift; in_data = flit;
        ctl(d, 1'b1, 1'b0, 4'd0);
        o = look(d);
        chk("in_ready_idle", 32'(o.in_ready), 32'd1);
        s0 = shs(d); o0 = ohs(d);
        tick();
        ctl(d, 1'b0, 1'b0, 4'd0);
        if (toggle) begin
            cfg_mode = ~mode; cfg_addr = ~addr; cfg_shift = shift + 2'd1; in_data = ~flit;
        end
        o = look(d);
        chk("s_valid_up", 32'(o.s_valid), 32'd1);
        chk("s_data", 32'(o.s_data), 32'(exp_port));
        chk("out_valid_in_sel", 32'(o.out_valid), 32'd0);
        chk("in_ready_sel", 32'(o.in_ready), 32'd0);
        for (int i = 0; i < s_stall; i++) begin
            tick();
            o = look(d);
            chk("s_valid_hold", 32'(o.s_valid), 32'd1);
            chk("s_data_hold", 32'(o.s_data), 32'(exp_port));
            chk("out_valid_stall_s", 32'(o.out_valid), 32'd0);
            chk("in_ready_stall_s", 32'(o.in_ready), 32'd0);
        end
        ctl(d, 1'b0, 1'b1, 4'd0);
        tick();
        ctl(d, 1'b0, 1'b0, others);
        o = look(d);
        chk("s_valid_down", 32'(o.s_valid), 32'd0);
        chk("out_valid", 32'(o.out_valid), 32'(onehot));
        chk("out_data", 32'(o.out_data), 32'(flit));
        chk("in_ready_data", 32'(o.in_ready), 32'd0);
        for (int i = 0; i < o_stall; i++) begin
            tick();
            o = look(d);
            chk("out_valid_hold", 32'(o.out_valid), 32'(onehot));
            chk("out_data_hold", 32'(o.out_data), 32'(flit));
            chk("s_valid_stall_o", 32'(o.s_valid), 32'd0);
            chk("in_ready_stall_o", 32'(o.in_ready), 32'd0);
        end
        ctl(d, 1'b0, 1'b0, onehot);
        tick();
        ctl(d, 1'b0, 1'b0, 4'd0);
        o = look(d);
        chk("out_valid_down", 32'(o.out_valid), 32'd0);
        chk("in_ready_back", 32'(o.in_ready), 32'd1);
        chk("s_hs_once", 32'(shs(d) - s0), 32'd1);
        chk("out_hs_once", 32'(ohs(d) - o0), 32'd1);
    endtask

    vec_t vt [8];

    initial begin
        obs_t o;
        int cnt, o0;
        RESET = 1'b1;
        ctl(2, 1'b0, 1'b0, 4'd0);
        cfg_mode = 1'b0; cfg_addr = 4'd0; cfg_mask = 4'd0; cfg_shift = 2'd0; in_data = 9'd0;
`ifdef NOC_ROUTE_STATS_EN
        stat_sel2 = 2'd0; stat_clr2 = 1'b0; stat_sel4 = 3'd0; stat_clr4 = 1'b0;
`endif
        vt[0] = '{2, 9'h1C0, 1'b1, 4'b1110, 4'b1110, 2'd0, 0};
        vt[1] = '{2, 9'h020, 1'b1, 4'b1110, 4'b1110, 2'd0, 1};
        vt[2] = '{4, 9'h120, 1'b0, 4'd0,    4'd0,    2'd2, 2};
        vt[3] = '{4, 9'h100, 1'b0, 4'd0,    4'd0,    2'd3, 1};
        vt[4] = '{4, 9'h080, 1'b1, 4'b0101, 4'b1111, 2'd0, 3};
        vt[5] = '{4, 9'h1A0, 1'b1, 4'b0001, 4'b0011, 2'd0, 0};
        vt[6] = '{2, 9'h060, 1'b0, 4'd0,    4'd0,    2'd0, 1};
        vt[7] = '{4, 9'h0C0, 1'b0, 4'd0,    4'd0,    2'd1, 3};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 2; d <= 4; d += 2) begin
            o = look(d);
            chk("rst_in_ready", 32'(o.in_ready), 32'd0);
            chk("rst_s_valid", 32'(o.s_valid), 32'd0);
            chk("rst_s_data", 32'(o.s_data), 32'd0);
            chk("rst_out_valid", 32'(o.out_valid), 32'd0);
            chk("rst_out_data", 32'(o.out_data), 32'd0);
        end
        RESET = 1'b0;
        tick();
        chk("post_rst_in_ready2", 32'(ir2), 32'd1);
        chk("post_rst_in_ready4", 32'(ir4), 32'd1);

        // Fixed routing table.
        for (int i = 0; i < 8; i++) begin
            send(vt[i].d, vt[i].flit, vt[i].mode, vt[i].addr, vt[i].mask, vt[i].shift,
                 vt[i].exp_port, 0, 0, 1'b0);
        end

        // Backpressure on both channels.
        send(4, 9'h0E0, 1'b0, 4'd0, 4'd0, 2'd1, 3, 5, 3, 1'b0);
        send(2, 9'h020, 1'b1, 4'b1110, 4'b1110, 2'd0, 1, 5, 3, 1'b0);

        // Config scrambled after acceptance; the next packet uses the new config.
        send(2, 9'h1C0, 1'b1, 4'b1110, 4'b1110, 2'd0, 0, 1, 1, 1'b1);
        send(2, 9'h1C0, 1'b0, 4'b0001, 4'b1110, 2'd1, 1, 0, 0, 1'b0);

        // Streaming with all readies high: one accept and one delivery per 3 cycles.
        cfg_mode = 1'b1; cfg_addr = 4'b1110; cfg_mask = 4'b1110; in_data = 9'h1C0;
        ctl(2, 1'b1, 1'b1, 4'b0011);
        cnt = 0; o0 = ohs2;
        for (int i = 0; i < 9; i++) begin
            if (ir2) cnt++;
            tick();
        end
        ctl(2, 1'b0, 1'b0, 4'd0);
        chk("stream_in_ready_cycles", 32'(cnt), 32'd3);
        chk("stream_out_hs", 32'(ohs2 - o0), 32'd3);
        chk("stream_idle_after", 32'(ir2), 32'd1);

        // Reset asserted while a packet waits in DATA.
        cfg_mode = 1'b0; cfg_shift = 2'd0; in_data = 9'h060;
        ctl(4, 1'b1, 1'b0, 4'd0);
        tick();
        ctl(4, 1'b0, 1'b1, 4'd0);
        tick();
        ctl(4, 1'b0, 1'b0, 4'd0);
        chk("pre_rst_out_valid", 32'(ov4), 32'b1000);
        #2 RESET = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(ov4), 32'd0);
        chk("rst_mid_out_data", 32'(od4), 32'd0);
        chk("rst_mid_in_ready", 32'(ir4), 32'd0);
        ctl(4, 1'b0, 1'b0, 4'b1111);
        o0 = ohs4;
        tick();
        chk("rst_mid_no_out_hs", 32'(ohs4 - o0), 32'd0);
        chk("rst_mid_in_ready_held", 32'(ir4), 32'd0);
        RESET = 1'b0;
        ctl(4, 1'b0, 1'b0, 4'd0);
        tick();
        send(4, 9'h060, 1'b0, 4'd0, 4'd0, 2'd0, 3, 0, 0, 1'b0);

        // Randomized packets against the routing model.
        for (int i = 0; i < 150; i++) begin
            int d, ep;
            logic [8:0] f;
            logic m;
            logic [3:0] ad, mk;
            logic [1:0] sh;
            d = ($urandom_range(0, 1) == 0) ? 2 : 4;
            f = 9'($urandom); m = 1'($urandom); ad = 4'($urandom); mk = 4'($urandom);
            sh = 2'($urandom);
            ep = model_port(d, f, m, ad, mk, sh);
            send(d, f, m, ad, mk, sh, ep, $urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom));
        end

`ifdef NOC_ROUTE_STATS_EN
        // Saturation of the port-0 counter, then clear against a live handshake.
        cfg_mode = 1'b1; cfg_addr = 4'b1110; cfg_mask = 4'b1110; in_data = 9'h1C0;
        stat_clr2 = 1'b1;
        tick();
        stat_clr2 = 1'b0;
        ctl(2, 1'b1, 1'b1, 4'b0011);
        repeat (70000 * 3) @(posedge CLK);
        @(negedge CLK);
        ctl(2, 1'b0, 1'b1, 4'b0011);
        repeat (3) tick();
        stat_sel2 = 2'd0;
        tick();
        chk("stat_saturated", 32'(stat_cnt2), 32'hFFFF);
        ctl(2, 1'b1, 1'b1, 4'b0011);
        tick();
        ctl(2, 1'b0, 1'b1, 4'b0011);
        tick();
        chk("stat_clr_setup_valid", 32'(ov2), 32'b01);
        stat_clr2 = 1'b1;
        tick();
        stat_clr2 = 1'b0;
        tick();
        chk("stat_clr_wins", 32'(stat_cnt2), 32'd0);
        ctl(2, 1'b0, 1'b0, 4'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
